shield_ctrl: RTL and testbench

//  Multi-charge, multi-hit player shield: a parametrised successor to the one-shot forcefield.

---
 rtl/shield_ctrl_pkg.sv | 16 +
 rtl/shield_ctrl_if.sv | 36 +++
 rtl/shield_ctrl_sprite.sv | 56 +++++
 rtl/shield_ctrl_timer.sv | 32 +++
 rtl/shield_ctrl.sv | 154 +++++++++++++++
 tb/tb_shield_ctrl.sv | 205 ++++++++++++++++++++
 6 files changed

// File: rtl/shield_ctrl_pkg.sv
// Shared types and constants for the multi-charge player shield.
package shield_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  // Wide enough for the longest frame timer (recharge) plus headroom.
  localparam int FRAME_W = 10;

  localparam int COLR_EVEN = 12;
  localparam int COLR_ODD  = 9;

endpackage

// File: rtl/shield_ctrl_if.sv
// Player/collision-side and pixel-mux-side signals of the shield controller.
interface shield_ctrl_if #(
  parameter int CORDW     = 16,
  parameter int COLR_BITS = 4,
  parameter int CW        = 2,
  parameter int HW        = 2
);
  import shield_pkg::*;

  logic                    frame;
  logic                    activate;
  logic                    impact;
  logic                    screen_line;
  logic signed [CORDW-1:0] screen_x;
  logic signed [CORDW-1:0] screen_y;
  logic signed [CORDW-1:0] ship_x;
  logic signed [CORDW-1:0] ship_y;
  logic                    available;
  logic [CW-1:0]           charges;
  logic [HW-1:0]           hp;
  state_t                  state_o;
  logic                    absorbed;
  logic                    drawing;
  logic [COLR_BITS-1:0]    pixel;

  modport master (
    output frame, activate, impact, screen_line, screen_x, screen_y, ship_x, ship_y,
    input  available, charges, hp, state_o, absorbed, drawing, pixel
  );

  modport slave (
    input  frame, activate, impact, screen_line, screen_x, screen_y, ship_x, ship_y,
    output available, charges, hp, state_o, absorbed, drawing, pixel
  );

endinterface

// File: rtl/shield_ctrl_sprite.sv
// Box sprite with row latch on the line strobe and on-screen clipping; two-tone rows.
module sprite #(
  parameter int CORDW     = 16,
  parameter int COLR_BITS = 4,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int WIDTH     = 39,
  parameter int HEIGHT    = 24,
  parameter int SCALE     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    line_i,
  input  logic signed [CORDW-1:0] sx_i,
  input  logic signed [CORDW-1:0] sy_i,
  input  logic signed [CORDW-1:0] sprx_i,
  input  logic signed [CORDW-1:0] spry_i,
  output logic                    drawing_o,
  output logic [COLR_BITS-1:0]    pix_o
);
  import shield_pkg::*;

  localparam logic signed [CORDW-1:0] SPR_W = CORDW'(WIDTH * SCALE);
  localparam logic signed [CORDW-1:0] SPR_H = CORDW'(HEIGHT * SCALE);
  localparam logic signed [CORDW-1:0] X_END = CORDW'(H_RES);
  localparam logic signed [CORDW-1:0] Y_END = CORDW'(V_RES);

  logic                 row_hit_q, row_odd_q, drawing_q;
  logic [COLR_BITS-1:0] pix_q;
  logic                 row_hit, col_hit, drawing_d;

  assign row_hit = !sy_i[CORDW-1] && (sy_i < Y_END) && (sy_i >= spry_i) && (sy_i < spry_i + SPR_H);
  assign col_hit = !sx_i[CORDW-1] && (sx_i < X_END) && (sx_i >= sprx_i) && (sx_i < sprx_i + SPR_W);
  assign drawing_d = en_i && row_hit_q && col_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_hit_q <= 1'b0;
      row_odd_q <= 1'b0;
      drawing_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      if (line_i) begin
        row_hit_q <= row_hit;
        row_odd_q <= sy_i[0] ^ spry_i[0];
      end
      drawing_q <= drawing_d;
      pix_q     <= drawing_d ? (row_odd_q ? COLR_BITS'(COLR_ODD) : COLR_BITS'(COLR_EVEN)) : '0;
    end
  end

  assign drawing_o = drawing_q;
  assign pix_o     = pix_q;

endmodule

// File: rtl/shield_ctrl_timer.sv
// Saturating frame down-counter: load wins over decrement, holds at zero.
module frame_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/shield_ctrl.sv
// Multi-charge, multi-hit player shield; all updates are stepped by the frame strobe.
//   state   | meaning
//   IDLE    | shield down, may activate if a charge is in stock
//   ACTIVE  | shield up, life and hit points counting down
//   LOCKOUT | shield just ended, activation refused until lock expires
module shield_ctrl
  import shield_pkg::*;
#(
  parameter int SCREEN_CORDW    = 16,
  parameter int COLR_BITS       = 4,
  parameter int H_RES           = 640,
  parameter int V_RES           = 480,
  parameter int WIDTH           = 39,
  parameter int HEIGHT          = 24,
  parameter int SCALE           = 1,
  parameter int ACTIVE_FRAMES   = 300,
  parameter int LOCKOUT_FRAMES  = 120,
  parameter int RECHARGE_FRAMES = 600,
  parameter int MAX_CHARGES     = 2,
  parameter int HIT_POINTS      = 3,
  parameter int WARN_FRAMES     = 60,
  parameter int BLINK_LOG2      = 3
) (
  input logic          clk,
  input logic          rst,
  shield_ctrl_if.slave bus
);

  localparam int CW = $clog2(MAX_CHARGES + 1);
  localparam int HW = $clog2(HIT_POINTS + 1);
  localparam logic [CW-1:0]      CHG_MAX = CW'(MAX_CHARGES);
  localparam logic [HW-1:0]      HP_FULL = HW'(HIT_POINTS);
  localparam logic [FRAME_W-1:0] RC_LAST = FRAME_W'(RECHARGE_FRAMES - 1);
  localparam logic [FRAME_W-1:0] WARN    = FRAME_W'(WARN_FRAMES);

  state_t                      state_q, state_d;
  logic [CW-1:0]               charges_q, charges_d;
  logic [HW-1:0]               hp_q, hp_d;
  logic [FRAME_W-1:0]          rc_q, rc_d, life_cnt, lock_cnt;
  logic                        act_flag_q, act_flag_d, hit_flag_q, hit_flag_d;
  logic                        absorbed_q, absorbed_d;
  logic                        act_seen, hit_seen, consume, recharge, shield_en;
  logic                        life_load, life_dec, life_zero, lock_load, lock_dec, lock_zero;
  logic signed [SCREEN_CORDW-1:0] spr_y;

  // A pulse coincident with the frame strobe still counts for that frame.
  assign act_seen   = act_flag_q | bus.activate;
  assign hit_seen   = hit_flag_q | bus.impact;
  assign act_flag_d = bus.frame ? 1'b0 : act_seen;
  assign hit_flag_d = bus.frame ? 1'b0 : hit_seen;

  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    absorbed_d = 1'b0;
    consume    = 1'b0;
    life_load  = 1'b0;
    life_dec   = 1'b0;
    lock_load  = 1'b0;
    lock_dec   = 1'b0;
    if (bus.frame) begin
      unique case (state_q)
        IDLE: if (act_seen && (charges_q != '0)) begin
          state_d   = ACTIVE;
          consume   = 1'b1;
          hp_d      = HP_FULL;
          life_load = 1'b1;
        end
        ACTIVE: begin
          life_dec = 1'b1;
          if (hit_seen) begin
            hp_d       = (hp_q != '0) ? hp_q - HW'(1) : '0;
            absorbed_d = 1'b1;
          end
          if ((hit_seen && (hp_q <= HW'(1))) || (life_cnt == FRAME_W'(1)) || life_zero) begin
            state_d   = LOCKOUT;
            hp_d      = '0;
            lock_load = 1'b1;
          end
        end
        LOCKOUT: begin
          lock_dec = 1'b1;
          if ((lock_cnt == FRAME_W'(1)) || lock_zero) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rc_d     = rc_q;
    recharge = 1'b0;
    if (charges_q >= CHG_MAX)
      rc_d = '0;
    else if (bus.frame) begin
      if (rc_q >= RC_LAST) begin
        rc_d     = '0;
        recharge = 1'b1;
      end else
        rc_d = rc_q + FRAME_W'(1);
    end
    charges_d = charges_q - CW'(consume) + CW'(recharge);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      charges_q  <= CHG_MAX;
      hp_q       <= '0;
      rc_q       <= '0;
      act_flag_q <= 1'b0;
      hit_flag_q <= 1'b0;
      absorbed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      charges_q  <= charges_d;
      hp_q       <= hp_d;
      rc_q       <= rc_d;
      act_flag_q <= act_flag_d;
      hit_flag_q <= hit_flag_d;
      absorbed_q <= absorbed_d;
    end
  end

  frame_timer #(.W(FRAME_W)) u_life (
    .clk(clk), .rst(rst), .load_i(life_load), .load_val_i(FRAME_W'(ACTIVE_FRAMES)),
    .dec_i(life_dec), .cnt_o(life_cnt), .zero_o(life_zero)
  );

  frame_timer #(.W(FRAME_W)) u_lock (
    .clk(clk), .rst(rst), .load_i(lock_load), .load_val_i(FRAME_W'(LOCKOUT_FRAMES)),
    .dec_i(lock_dec), .cnt_o(lock_cnt), .zero_o(lock_zero)
  );

  // Blinks during the warning window by gating on one bit of the life count.
  assign shield_en = (state_q == ACTIVE) && ((life_cnt > WARN) || life_cnt[BLINK_LOG2]);
  assign spr_y     = bus.ship_y - SCREEN_CORDW'(HEIGHT * SCALE);

  sprite #(
    .CORDW(SCREEN_CORDW), .COLR_BITS(COLR_BITS), .H_RES(H_RES), .V_RES(V_RES),
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SCALE(SCALE)
  ) u_sprite (
    .clk(clk), .rst(~rst), .en_i(shield_en), .line_i(bus.screen_line),
    .sx_i(bus.screen_x), .sy_i(bus.screen_y), .sprx_i(bus.ship_x), .spry_i(spr_y),
    .drawing_o(bus.drawing), .pix_o(bus.pixel)
  );

  assign bus.available = (state_q == IDLE) && (charges_q != '0);
  assign bus.charges   = charges_q;
  assign bus.hp        = hp_q;
  assign bus.state_o   = state_q;
  assign bus.absorbed  = absorbed_q;

endmodule

// File: tb/tb_shield_ctrl.sv
// Directed bench for shield_ctrl: activation, hits, timeout blink, recharge, reset.
module tb_shield_ctrl;
  import shield_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;
  int   absorbed_cnt = 0;

  shield_ctrl_if bus_if ();

  shield_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_if.absorbed === 1'b1) absorbed_cnt++;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame strobe, optionally with coincident activate/impact pulses.
  task automatic frame(input bit act, input bit hit);
    @(negedge clk);
    bus_if.frame = 1'b1; bus_if.activate = act; bus_if.impact = hit;
    @(negedge clk);
    bus_if.frame = 1'b0; bus_if.activate = 1'b0; bus_if.impact = 1'b0;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0);
  endtask

  task automatic pulse_act();
    @(negedge clk); bus_if.activate = 1'b1;
    @(negedge clk); bus_if.activate = 1'b0;
  endtask

  task automatic pulse_hit();
    @(negedge clk); bus_if.impact = 1'b1;
    @(negedge clk); bus_if.impact = 1'b0;
  endtask

  task automatic probe(input int x, input int y);
    bus_if.screen_y = 16'(y); bus_if.screen_line = 1'b1;
    @(negedge clk);
    bus_if.screen_line = 1'b0; bus_if.screen_x = 16'(x);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus_if.frame = 1'b0; bus_if.activate = 1'b0; bus_if.impact = 1'b0;
    bus_if.screen_line = 1'b0; bus_if.screen_x = '0; bus_if.screen_y = '0;
    bus_if.ship_x = 16'sd100; bus_if.ship_y = 16'sd200;   // shield box x 100..138, y 176..199
    repeat (3) @(negedge clk);
    check_eq("rst_state", int'(bus_if.state_o), 0);
    check_eq("rst_charges", int'(bus_if.charges), 2);
    check_eq("rst_hp", int'(bus_if.hp), 0);
    check_eq("rst_avail", int'(bus_if.available), 1);
    check_eq("rst_absorbed", int'(bus_if.absorbed), 0);
    rst = 1'b1;
    @(negedge clk);
    probe(100, 180);
    check_eq("idle_nodraw", int'(bus_if.drawing), 0);

    // Test 1: sticky activate, consumed on frame A.
    pulse_act();
    check_eq("pre_frame_state", int'(bus_if.state_o), 0);
    frame(1'b0, 1'b0);
    check_eq("act_state", int'(bus_if.state_o), 1);
    check_eq("act_charges", int'(bus_if.charges), 1);
    check_eq("act_hp", int'(bus_if.hp), 3);
    check_eq("act_avail", int'(bus_if.available), 0);
    probe(100, 180);
    check_eq("draw_tl", int'(bus_if.drawing), 1);
    check_eq("pix_even", int'(bus_if.pixel), 12);
    probe(138, 199);
    check_eq("draw_br", int'(bus_if.drawing), 1);
    check_eq("pix_odd", int'(bus_if.pixel), 9);
    probe(139, 180);
    check_eq("draw_right_out", int'(bus_if.drawing), 0);
    check_eq("pix_out", int'(bus_if.pixel), 0);
    probe(99, 180);
    check_eq("draw_left_out", int'(bus_if.drawing), 0);
    probe(110, 175);
    check_eq("draw_top_out", int'(bus_if.drawing), 0);
    probe(110, 200);
    check_eq("draw_bot_out", int'(bus_if.drawing), 0);

    // Test 2: three hits on separate frames (A+1..A+3).
    pulse_hit();
    frame(1'b0, 1'b0);
    check_eq("hit1_hp", int'(bus_if.hp), 2);
    check_eq("hit1_absorbed", int'(bus_if.absorbed), 1);
    @(negedge clk);
    check_eq("hit1_absorbed_end", int'(bus_if.absorbed), 0);
    frame(1'b0, 1'b1);
    check_eq("hit2_hp", int'(bus_if.hp), 1);
    check_eq("hit2_state", int'(bus_if.state_o), 1);
    pulse_hit();
    frame(1'b0, 1'b0);
    check_eq("hit3_hp", int'(bus_if.hp), 0);
    check_eq("hit3_state", int'(bus_if.state_o), 2);
    check_eq("hit3_absorbed", int'(bus_if.absorbed), 1);
    @(negedge clk);
    check_eq("absorbed_cnt3", absorbed_cnt, 3);
    // Activate during lockout (A+4) is dropped.
    pulse_act();
    frame(1'b0, 1'b0);
    check_eq("lock_act_state", int'(bus_if.state_o), 2);
    check_eq("lock_act_charges", int'(bus_if.charges), 1);
    run_frames(118);                                      // A+122
    check_eq("lock_119", int'(bus_if.state_o), 2);
    frame(1'b0, 1'b0);                                    // A+123
    check_eq("lock_done", int'(bus_if.state_o), 0);
    check_eq("lock_done_avail", int'(bus_if.available), 1);

    // Test 3: activate at A+124, five impacts within A+125.
    frame(1'b1, 1'b0);
    check_eq("act2_state", int'(bus_if.state_o), 1);
    check_eq("act2_charges", int'(bus_if.charges), 0);
    for (int i = 0; i < 5; i++) pulse_hit();
    frame(1'b0, 1'b0);
    check_eq("multi_hp", int'(bus_if.hp), 2);
    repeat (2) @(negedge clk);
    check_eq("multi_absorbed_cnt", absorbed_cnt, 4);
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b1);                                    // A+127
    check_eq("act2_lock", int'(bus_if.state_o), 2);
    run_frames(120);                                      // A+247
    check_eq("act2_idle", int'(bus_if.state_o), 0);
    check_eq("empty_avail", int'(bus_if.available), 0);

    // Test 5: no charges left, recharge lands at A+600.
    frame(1'b1, 1'b0);                                    // A+248
    check_eq("empty_act_state", int'(bus_if.state_o), 0);
    run_frames(351);                                      // A+599
    check_eq("rc_599_charges", int'(bus_if.charges), 0);
    check_eq("rc_599_avail", int'(bus_if.available), 0);
    frame(1'b0, 1'b0);                                    // A+600
    check_eq("rc_600_charges", int'(bus_if.charges), 1);
    check_eq("rc_600_avail", int'(bus_if.available), 1);

    // Test 4: unhit shield times out after 300 frames; blink in last 60.
    frame(1'b1, 1'b0);                                    // A+601, life 300
    check_eq("act3_state", int'(bus_if.state_o), 1);
    run_frames(239);  probe(100, 180);
    check_eq("life61_draw", int'(bus_if.drawing), 1);
    run_frames(5);    probe(100, 180);
    check_eq("life56_draw", int'(bus_if.drawing), 1);
    run_frames(1);    probe(100, 180);
    check_eq("life55_draw", int'(bus_if.drawing), 0);
    run_frames(7);    probe(100, 180);
    check_eq("life48_draw", int'(bus_if.drawing), 0);
    run_frames(1);    probe(100, 180);
    check_eq("life47_draw", int'(bus_if.drawing), 1);
    run_frames(46);   probe(100, 180);
    check_eq("life1_draw", int'(bus_if.drawing), 0);
    check_eq("life1_state", int'(bus_if.state_o), 1);
    check_eq("life1_hp", int'(bus_if.hp), 3);
    frame(1'b0, 1'b0);                                    // A+901
    check_eq("timeout_state", int'(bus_if.state_o), 2);
    check_eq("timeout_hp", int'(bus_if.hp), 0);
    check_eq("timeout_absorbed_cnt", absorbed_cnt, 6);
    run_frames(298);                                      // A+1199
    check_eq("rc2_1199_charges", int'(bus_if.charges), 0);
    check_eq("rc2_1199_state", int'(bus_if.state_o), 0);
    frame(1'b0, 1'b0);                                    // A+1200
    check_eq("rc2_1200_charges", int'(bus_if.charges), 1);

    // Test 6: reset mid-ACTIVE clears everything without a clock edge.
    frame(1'b1, 1'b0);
    check_eq("act4_state", int'(bus_if.state_o), 1);
    probe(100, 180);
    check_eq("act4_draw", int'(bus_if.drawing), 1);
    rst = 1'b0;
    #1;
    check_eq("midrst_state", int'(bus_if.state_o), 0);
    check_eq("midrst_charges", int'(bus_if.charges), 2);
    check_eq("midrst_hp", int'(bus_if.hp), 0);
    check_eq("midrst_draw", int'(bus_if.drawing), 0);
    check_eq("midrst_avail", int'(bus_if.available), 1);
    @(negedge clk);
    rst = 1'b1;
    frame(1'b0, 1'b0);
    check_eq("post_rst_state", int'(bus_if.state_o), 0);
    check_eq("post_rst_charges", int'(bus_if.charges), 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
